// File: rtl/approx_add_pkg.sv
// Shared types and helpers for the approximate adder: mode encoding, saturating add and
// parameter-legality check used at elaboration.
package approx_add_pkg;

   typedef enum logic [1:0] {
      MODE_EXACT = 2'd0,
      MODE_TRUNC = 2'd1,
      MODE_LOA   = 2'd2,
      MODE_RSVD  = 2'd3
   } mode_e;

   // Unsigned a+b clamped to the all-ones value of a w-bit field (w in 1..64).
   function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                           input int unsigned w);
      logic [64:0] sum;
      logic [64:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = (65'd1 << w) - 65'd1;
      return (sum > lim) ? lim[63:0] : sum[63:0];
   endfunction

   function automatic bit params_ok(input int unsigned width, input int unsigned approx_bits,
                                    input int unsigned stages, input int unsigned err_w,
                                    input int unsigned cnt_w);
      return (width >= 1) && (approx_bits <= width) && (stages >= 1) &&
             (err_w >= 1) && (err_w <= 64) && (cnt_w >= 1) && (cnt_w <= 64);
   endfunction

endpackage

// File: rtl/approx_add_core.sv
// Combinational approximate adder: selects exact, truncated or lower-part-OR sum and reports
// the absolute distance from the exact sum.
module approx_add_core
   import approx_add_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned APPROX_BITS = 4
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [1:0]       mode_i,
   output logic [WIDTH:0]   sum_o,
   output logic [WIDTH:0]   err_o
);

   logic [WIDTH:0] exact;
   logic [WIDTH:0] trunc;
   logic [WIDTH:0] loa;

   assign exact = {1'b0, a_i} + {1'b0, b_i};

   if (APPROX_BITS == 0) begin : g_exact
      assign trunc = exact;
      assign loa   = exact;
   end else if (APPROX_BITS == WIDTH) begin : g_all
      assign trunc = '0;
      assign loa   = {a_i[WIDTH-1] & b_i[WIDTH-1], a_i | b_i};
   end else begin : g_split
      localparam int unsigned K  = APPROX_BITS;
      localparam int unsigned HW = WIDTH - APPROX_BITS;
      logic [HW:0] hsum;
      logic [HW:0] hsum_c;
      logic        cin;
      assign hsum   = {1'b0, a_i[WIDTH-1:K]} + {1'b0, b_i[WIDTH-1:K]};
      // LOA carry-in guesses the lower carry from the top approximated bit pair only
      assign cin    = a_i[K-1] & b_i[K-1];
      assign hsum_c = hsum + {{HW{1'b0}}, cin};
      assign trunc  = {hsum, {K{1'b0}}};
      assign loa    = {hsum_c, a_i[K-1:0] | b_i[K-1:0]};
   end

   always_comb begin
      sum_o = exact;
      case (mode_i)
         MODE_TRUNC: sum_o = trunc;
         MODE_LOA:   sum_o = loa;
         default:    sum_o = exact;
      endcase
   end

   assign err_o = (sum_o >= exact) ? (sum_o - exact) : (exact - sum_o);

endmodule

// File: rtl/approx_add_pipe.sv
// Pipelined approximate adder with valid/ready handshake and an error monitor that
// accumulates statistics over consumed results.
module approx_add_pipe
   import approx_add_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned APPROX_BITS = 4,
   parameter int unsigned STAGES      = 2,
   parameter int unsigned ERR_W       = 24,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_sum,
   output logic [1:0]       out_mode,
   input  logic             err_clr,
   output logic [ERR_W-1:0] err_acc,
   output logic [CNT_W-1:0] err_cnt,
   output logic [WIDTH:0]   err_max
);

   if (!params_ok(WIDTH, APPROX_BITS, STAGES, ERR_W, CNT_W)) begin : g_bad_params
      $error("approx_add_pipe: illegal parameter combination");
   end

   logic             advance;
   logic             out_fire;
   logic [WIDTH:0]   core_sum;
   logic [WIDTH:0]   core_err;

   logic [STAGES-1:0] vld_q, vld_d;
   logic [WIDTH:0]    sum_q  [STAGES];
   logic [WIDTH:0]    sum_d  [STAGES];
   logic [WIDTH:0]    err_q  [STAGES];
   logic [WIDTH:0]    err_d  [STAGES];
   logic [1:0]        mode_q [STAGES];
   logic [1:0]        mode_d [STAGES];

   logic [ERR_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]   max_q, max_d;

   approx_add_core #(
      .WIDTH       (WIDTH),
      .APPROX_BITS (APPROX_BITS)
   ) u_core (
      .a_i    (in_a),
      .b_i    (in_b),
      .mode_i (in_mode),
      .sum_o  (core_sum),
      .err_o  (core_err)
   );

   // Whole pipeline moves as one; bubbles are kept so latency is fixed.
   assign out_valid = vld_q[STAGES-1];
   assign advance   = !out_valid || out_ready;
   assign in_ready  = advance;
   assign out_fire  = out_valid && out_ready;
   assign out_sum   = sum_q[STAGES-1];
   assign out_mode  = mode_q[STAGES-1];

   always_comb begin
      vld_d  = vld_q;
      sum_d  = sum_q;
      err_d  = err_q;
      mode_d = mode_q;
      if (advance) begin
         vld_d[0]  = in_valid;
         sum_d[0]  = core_sum;
         err_d[0]  = core_err;
         mode_d[0] = in_mode;
         for (int unsigned i = 1; i < STAGES; i++) begin
            vld_d[i]  = vld_q[i-1];
            sum_d[i]  = sum_q[i-1];
            err_d[i]  = err_q[i-1];
            mode_d[i] = mode_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int unsigned i = 0; i < STAGES; i++) begin
            sum_q[i]  <= '0;
            err_q[i]  <= '0;
            mode_q[i] <= '0;
         end
      end else begin
         vld_q  <= vld_d;
         sum_q  <= sum_d;
         err_q  <= err_d;
         mode_q <= mode_d;
      end
   end

   // Clear has priority over a coincident handshake; that result is not counted.
   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      max_d = max_q;
      if (err_clr) begin
         acc_d = '0;
         cnt_d = '0;
         max_d = '0;
      end else if (out_fire) begin
         acc_d = ERR_W'(sat_add(64'(acc_q), 64'(err_q[STAGES-1]), ERR_W));
         cnt_d = CNT_W'(sat_add(64'(cnt_q), 64'd1, CNT_W));
         if (err_q[STAGES-1] > max_q) begin
            max_d = err_q[STAGES-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
         max_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         max_q <= max_d;
      end
   end

   assign err_acc = acc_q;
   assign err_cnt = cnt_q;
   assign err_max = max_q;

endmodule

// File: tb/tb_approx_add_pipe.sv
// Directed and randomised checks of approx_add_pipe; three instances share stimulus to cover
// the default build, narrow saturating counters and the K=0 build.
module tb_approx_add_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic [1:0] in_mode;
   logic       out_ready;
   logic       err_clr;

   logic        in_ready, out_valid;
   logic [8:0]  out_sum, err_max;
   logic [1:0]  out_mode;
   logic [23:0] err_acc;
   logic [15:0] err_cnt;

   logic        in_ready2, out_valid2;
   logic [8:0]  out_sum2, err_max2;
   logic [1:0]  out_mode2;
   logic [3:0]  err_acc2;
   logic [1:0]  err_cnt2;

   logic        in_ready3, out_valid3;
   logic [8:0]  out_sum3, err_max3;
   logic [1:0]  out_mode3;
   logic [23:0] err_acc3;
   logic [15:0] err_cnt3;

   int n_asrt = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   approx_add_pipe #(.WIDTH(8), .APPROX_BITS(4), .STAGES(2), .ERR_W(24), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
      .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_mode(out_mode), .err_clr(err_clr), .err_acc(err_acc),
      .err_cnt(err_cnt), .err_max(err_max)
   );

   approx_add_pipe #(.WIDTH(8), .APPROX_BITS(4), .STAGES(2), .ERR_W(4), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_a(in_a),
      .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid2), .out_ready(out_ready),
      .out_sum(out_sum2), .out_mode(out_mode2), .err_clr(err_clr), .err_acc(err_acc2),
      .err_cnt(err_cnt2), .err_max(err_max2)
   );

   approx_add_pipe #(.WIDTH(8), .APPROX_BITS(0), .STAGES(2), .ERR_W(24), .CNT_W(16)) u_k0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3), .in_a(in_a),
      .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid3), .out_ready(out_ready),
      .out_sum(out_sum3), .out_mode(out_mode3), .err_clr(err_clr), .err_acc(err_acc3),
      .err_cnt(err_cnt3), .err_max(err_max3)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference for K=4, W=8 written as integer shift arithmetic.
   function automatic logic [8:0] model_sum(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] m);
      int unsigned ai, bi, hs, cin;
      ai  = a;
      bi  = b;
      hs  = (ai >> 4) + (bi >> 4);
      cin = (ai >> 3) & (bi >> 3) & 1;
      case (m)
         2'd1:    return 9'(hs << 4);
         2'd2:    return 9'(((hs + cin) << 4) | ((ai | bi) & 15));
         default: return 9'(ai + bi);
      endcase
   endfunction

   // One beat through an empty pipe with out_ready held high.
   task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                       input logic [8:0] exp_sum, input logic [8:0] exp_k0);
      check("in_ready_idle", 64'(in_ready), 64'd1);
      in_a = a; in_b = b; in_mode = m; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("latency_mid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      check("latency_valid", 64'(out_valid), 64'd1);
      check("sum", 64'(out_sum), 64'(exp_sum));
      check("mode", 64'(out_mode), 64'(m));
      check("sum_k0", 64'(out_sum3), 64'(exp_k0));
      @(posedge clk); #1;
      check("drained", 64'(out_valid), 64'd0);
   endtask

   typedef struct {
      logic [8:0] sum;
      logic [8:0] exact;
      logic [1:0] mode;
   } beat_t;

   initial begin
      beat_t      q[$];
      beat_t      bt;
      int         sent, got, cyc;
      int         m_acc, m_cnt, m_max, e;
      logic       need_new, stalled_prev;
      logic [8:0] sum_prev;
      logic [1:0] mode_prev;

      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0;
      out_ready = 1'b0; err_clr = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_sum", 64'(out_sum), 64'd0);
      check("rst_out_mode", 64'(out_mode), 64'd0);
      check("rst_acc", 64'(err_acc), 64'd0);
      check("rst_cnt", 64'(err_cnt), 64'd0);
      check("rst_max", 64'(err_max), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 0x0F + 0x01 in modes 0/1/2
      beat(8'h0F, 8'h01, 2'd0, 9'h010, 9'h010);
      beat(8'h0F, 8'h01, 2'd1, 9'h000, 9'h010);
      beat(8'h0F, 8'h01, 2'd2, 9'h00F, 9'h010);
      check("acc_0f", 64'(err_acc), 64'd17);
      check("cnt_0f", 64'(err_cnt), 64'd3);
      check("max_0f", 64'(err_max), 64'd16);
      check("sat_acc_0f", 64'(err_acc2), 64'd15);
      check("sat_cnt_0f", 64'(err_cnt2), 64'd3);

      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      check("clr_acc", 64'(err_acc), 64'd0);
      check("clr_cnt", 64'(err_cnt), 64'd0);
      check("clr_max", 64'(err_max), 64'd0);

      // 0xFF + 0xFF in modes 0/1/2, then reserved mode 3
      beat(8'hFF, 8'hFF, 2'd0, 9'h1FE, 9'h1FE);
      beat(8'hFF, 8'hFF, 2'd1, 9'h1E0, 9'h1FE);
      beat(8'hFF, 8'hFF, 2'd2, 9'h1FF, 9'h1FE);
      check("acc_ff", 64'(err_acc), 64'd31);
      check("cnt_ff", 64'(err_cnt), 64'd3);
      check("max_ff", 64'(err_max), 64'd30);
      beat(8'hFF, 8'hFF, 2'd3, 9'h1FE, 9'h1FE);
      check("acc_rsvd", 64'(err_acc), 64'd31);
      check("cnt_rsvd", 64'(err_cnt), 64'd4);
      check("sat_acc_stuck", 64'(err_acc2), 64'd15);
      check("sat_cnt_stuck", 64'(err_cnt2), 64'd3);

      // Random back-to-back traffic with random back-pressure
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      m_acc = 0; m_cnt = 0; m_max = 0;
      sent = 0; got = 0; cyc = 0;
      need_new = 1'b1; stalled_prev = 1'b0; sum_prev = '0; mode_prev = '0;
      while ((sent < 100 || q.size() > 0) && cyc < 3000) begin
         if (stalled_prev) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_sum", 64'(out_sum), 64'(sum_prev));
            check("stall_mode", 64'(out_mode), 64'(mode_prev));
         end
         if (sent < 100) begin
            if (need_new) begin
               in_a    = 8'($urandom);
               in_b    = 8'($urandom);
               in_mode = 2'($urandom_range(0, 3));
            end
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         out_ready = 1'($urandom_range(0, 1));
         #1;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("spurious_out", 64'(q.size()), 64'd1);
            end else begin
               bt = q.pop_front();
               check("rnd_sum", 64'(out_sum), 64'(bt.sum));
               check("rnd_mode", 64'(out_mode), 64'(bt.mode));
               check("rnd_k0_exact", 64'(out_sum3), 64'(bt.exact));
               e = (bt.sum >= bt.exact) ? int'(bt.sum - bt.exact) : int'(bt.exact - bt.sum);
               m_acc += e;
               m_cnt++;
               if (e > m_max) m_max = e;
               got++;
            end
         end
         need_new = in_valid && in_ready;
         if (need_new) begin
            bt.sum   = model_sum(in_a, in_b, in_mode);
            bt.exact = 9'({1'b0, in_a} + {1'b0, in_b});
            bt.mode  = in_mode;
            q.push_back(bt);
            sent++;
         end
         stalled_prev = out_valid && !out_ready;
         sum_prev     = out_sum;
         mode_prev    = out_mode;
         @(posedge clk); #1;
         cyc++;
      end
      check("rnd_received", 64'(got), 64'd100);
      check("rnd_acc", 64'(err_acc), 64'(m_acc));
      check("rnd_cnt", 64'(err_cnt), 64'(m_cnt));
      check("rnd_max", 64'(err_max), 64'(m_max));
      check("k0_max", 64'(err_max3), 64'd0);
      check("k0_acc", 64'(err_acc3), 64'd0);
      in_valid = 1'b0;

      // Clear coincident with output handshake
      out_ready = 1'b1;
      in_a = 8'h0F; in_b = 8'h01; in_mode = 2'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("clrhs_valid", 64'(out_valid), 64'd1);
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      check("clrhs_consumed", 64'(out_valid), 64'd0);
      check("clrhs_acc", 64'(err_acc), 64'd0);
      check("clrhs_cnt", 64'(err_cnt), 64'd0);
      check("clrhs_max", 64'(err_max), 64'd0);

      // Reset with two beats in flight
      beat(8'h0F, 8'h01, 2'd1, 9'h000, 9'h010);
      check("pre_rst_acc", 64'(err_acc), 64'd16);
      check("pre_rst_cnt", 64'(err_cnt), 64'd1);
      in_a = 8'h01; in_b = 8'h02; in_mode = 2'd0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_a = 8'h03; in_b = 8'h04;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("inflight_valid", 64'(out_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 64'(out_valid), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_acc", 64'(err_acc), 64'd0);
      check("midrst_cnt", 64'(err_cnt), 64'd0);
      check("midrst_max", 64'(err_max), 64'd0);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("post_rst_idle", 64'(out_valid), 64'd0);
      end
      check("post_rst_cnt", 64'(err_cnt), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
